// File: rtl/adder_bist_if.sv
// adder_bist_if: connection between the BIST controller and the adder under test.
//   a_o, b_o, cin_o : operands driven by the controller (master)
//   sum_i, cout_i   : result returned by the adder (slave)
// The signal names are written from the controller's point of view.
interface adder_bist_if #(
  parameter int WIDTH = 1
);
  logic [WIDTH-1:0] a_o;
  logic [WIDTH-1:0] b_o;
  logic             cin_o;
  logic [WIDTH-1:0] sum_i;
  logic             cout_i;

  modport master (output a_o, b_o, cin_o, input sum_i, cout_i);
  modport slave  (input a_o, b_o, cin_o, output sum_i, cout_i);
endinterface

// File: rtl/adder_bist_ctrl.sv
// adder_bist_ctrl: self-test controller for a WIDTH-bit ripple adder.
// It walks every {a,b,cin} vector V (2*WIDTH+1 bits) into the adder, holds
// each vector for SETTLE cycles, then spends one CHECK cycle comparing
// {cout,sum} against a+b+cin. Mismatches are counted in a saturating
// counter, and the first failing V is latched. The end of a run is
// signalled by a 1-cycle done pulse together with pass.
//
// Ports
//   clk, rst_n     clock, asynchronous active-low reset
//   start          run request, accepted in IDLE only
//   adder          adder_bist_if.master: a_o/b_o/cin_o out, sum_i/cout_i in
//   busy           high during APPLY/CHECK of the run
//   done           1-cycle pulse when the run completes
//   pass           last run had zero mismatches
//   err_cnt        saturating mismatch count
//   first_fail_vec V of the first mismatch (meaningful when err_cnt != 0)
//   fi_i           (ADDER_BIST_FAULT_INJ_EN only) inverts expected bit 0
//                  during CHECK, so that the checker can be tested
//
// Optional feature: define ADDER_BIST_FAULT_INJ_EN to add the fi_i port.
module adder_bist_ctrl #(
  parameter int WIDTH     = 1,
  parameter int SETTLE    = 1,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
`ifdef ADDER_BIST_FAULT_INJ_EN
  input  logic                 fi_i,
`endif
  adder_bist_if.master         adder,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic [2*WIDTH:0]     first_fail_vec
);

  localparam int VW    = 2*WIDTH + 1;
  localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [1:0] {IDLE, APPLY, CHECK, DONE} state_e;

  state_e               state_q, state_d;
  logic [VW-1:0]        vec_q, vec_d;
  logic [VW-1:0]        drv_q, drv_d;      // registered vector on the adder pins
  logic [CNT_W-1:0]     settle_q, settle_d;
  logic [ERR_CNT_W-1:0] err_q, err_d;
  logic [VW-1:0]        ffv_q, ffv_d;
  logic                 pass_q, pass_d;

  logic [WIDTH:0]       exp_sum;
  logic [WIDTH:0]       exp_chk;
  logic                 mismatch;
  logic                 last_vec;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = APPLY;
      APPLY:   if (settle_q == CNT_W'(SETTLE-1)) state_d = CHECK;
      CHECK:   state_d = last_vec ? DONE : APPLY;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      APPLY, CHECK: busy = 1'b1;
      DONE:         done = 1'b1;
      default:      ;
    endcase
  end

  // The golden value is full width (WIDTH+1 bits), so the carry is checked too.
  assign exp_sum = {1'b0, vec_q[VW-1:WIDTH+1]} + {1'b0, vec_q[WIDTH:1]}
                 + {{WIDTH{1'b0}}, vec_q[0]};
`ifdef ADDER_BIST_FAULT_INJ_EN
  assign exp_chk = exp_sum ^ {{WIDTH{1'b0}}, fi_i};
`else
  assign exp_chk = exp_sum;
`endif
  // Case inequality, so an X or Z from the adder counts as a failure.
  assign mismatch = ({adder.cout_i, adder.sum_i} !== exp_chk);
  assign last_vec = (vec_q == {VW{1'b1}});

  // Datapath next-state logic
  always_comb begin
    vec_d    = vec_q;
    drv_d    = drv_q;
    settle_d = settle_q;
    err_d    = err_q;
    ffv_d    = ffv_q;
    pass_d   = pass_q;
    case (state_q)
      IDLE: if (start) begin
        vec_d    = '0;
        drv_d    = '0;
        settle_d = '0;
        err_d    = '0;
        ffv_d    = '0;
        pass_d   = 1'b0;
      end
      APPLY: begin
        if (settle_q == CNT_W'(SETTLE-1)) settle_d = '0;
        else                              settle_d = settle_q + 1'b1;
      end
      CHECK: begin
        if (mismatch) begin
          if (err_q != {ERR_CNT_W{1'b1}}) err_d = err_q + 1'b1;
          if (err_q == '0)                ffv_d = vec_q;
        end
        if (last_vec) begin
          drv_d  = '0;
          // pass is settled on entry to DONE, so it is valid together with done.
          pass_d = (err_q == '0) && !mismatch;
        end else begin
          vec_d = vec_q + 1'b1;
          drv_d = vec_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec_q    <= '0;
      drv_q    <= '0;
      settle_q <= '0;
      err_q    <= '0;
      ffv_q    <= '0;
      pass_q   <= 1'b0;
    end else begin
      vec_q    <= vec_d;
      drv_q    <= drv_d;
      settle_q <= settle_d;
      err_q    <= err_d;
      ffv_q    <= ffv_d;
      pass_q   <= pass_d;
    end
  end

  assign adder.a_o      = drv_q[VW-1:WIDTH+1];
  assign adder.b_o      = drv_q[WIDTH:1];
  assign adder.cin_o    = drv_q[0];
  assign err_cnt        = err_q;
  assign first_fail_vec = ffv_q;
  assign pass           = pass_q;

endmodule

// File: tb/tb_adder_bist_ctrl.sv
module tb_adder_bist_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic start2 = 1'b0;
  logic fi = 1'b0;
  int   mode = 0;   // 0 golden, 1 cout stuck at 0

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // DUT 1: WIDTH=1, SETTLE=1
  adder_bist_if #(.WIDTH(1)) bus1 ();
  logic       busy, done, pass;
  logic [7:0] err_cnt;
  logic [2:0] ffv;
  logic [1:0] s1;

  assign s1          = {1'b0, bus1.a_o} + {1'b0, bus1.b_o} + {1'b0, bus1.cin_o};
  assign bus1.sum_i  = s1[0];
  assign bus1.cout_i = (mode == 1) ? 1'b0 : s1[1];

  adder_bist_ctrl #(.WIDTH(1), .SETTLE(1), .ERR_CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
`ifdef ADDER_BIST_FAULT_INJ_EN
    .fi_i(fi),
`endif
    .adder(bus1.master), .busy(busy), .done(done), .pass(pass),
    .err_cnt(err_cnt), .first_fail_vec(ffv)
  );

  // DUT 2: WIDTH=2, ERR_CNT_W=4, adder with inverted sum
  adder_bist_if #(.WIDTH(2)) bus2 ();
  logic       busy2, done2, pass2;
  logic [3:0] err2;
  logic [4:0] ffv2;
  logic [2:0] s2;

  assign s2          = {1'b0, bus2.a_o} + {1'b0, bus2.b_o} + {2'b0, bus2.cin_o};
  assign bus2.sum_i  = ~s2[1:0];
  assign bus2.cout_i = s2[2];

  adder_bist_ctrl #(.WIDTH(2), .SETTLE(1), .ERR_CNT_W(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2),
`ifdef ADDER_BIST_FAULT_INJ_EN
    .fi_i(1'b0),
`endif
    .adder(bus2.master), .busy(busy2), .done(done2), .pass(pass2),
    .err_cnt(err2), .first_fail_vec(ffv2)
  );

  // Trace of one WIDTH=1 run, indexed by cycle number (cycle 1 = after start edge)
  logic       busy_tr [0:24];
  logic [2:0] vec_tr  [0:24];
  int         done_cyc;
  int         done_cnt;

  task automatic run_w1(input bit restart);
    done_cyc = -1;
    done_cnt = 0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int n = 1; n <= 24; n++) begin
      busy_tr[n] = busy;
      vec_tr[n]  = {bus1.a_o, bus1.b_o, bus1.cin_o};
      if (done === 1'b1) begin done_cnt++; done_cyc = n; end
      start = restart && (n == 5 || n == 17);
      @(posedge clk); #1;
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    #12;
    checks++;
    if ({busy, done, pass, err_cnt, ffv, bus1.a_o, bus1.b_o, bus1.cin_o} !== '0) begin
      errors++; $display("FAIL reset_outputs got %b exp 0",
        {busy, done, pass, err_cnt, ffv, bus1.a_o, bus1.b_o, bus1.cin_o});
    end
    checks++;
    if ({busy2, done2, pass2, err2, ffv2} !== '0) begin
      errors++; $display("FAIL reset_outputs2 got %b exp 0", {busy2, done2, pass2, err2, ffv2});
    end
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL idle_after_reset busy=%b exp 0", busy); end
  endtask

  task automatic test_golden;
    mode = 0;
    run_w1(1'b0);
    for (int n = 1; n <= 16; n++) begin
      checks++;
      if (vec_tr[n] !== 3'((n-1)/2) || busy_tr[n] !== 1'b1) begin
        errors++; $display("FAIL golden_vec cyc %0d got vec=%0d busy=%b exp vec=%0d busy=1",
          n, vec_tr[n], busy_tr[n], (n-1)/2);
      end
    end
    checks++;
    if (busy_tr[17] !== 1'b0 || vec_tr[17] !== 3'd0) begin
      errors++; $display("FAIL golden_done_cycle_drive busy=%b vec=%0d exp 0 0", busy_tr[17], vec_tr[17]);
    end
    checks++;
    if (done_cyc != 17 || done_cnt != 1) begin
      errors++; $display("FAIL golden_done got cyc=%0d cnt=%0d exp cyc=17 cnt=1", done_cyc, done_cnt);
    end
    checks++;
    if (pass !== 1'b1 || err_cnt !== 8'd0) begin
      errors++; $display("FAIL golden_result got pass=%b err=%0d exp pass=1 err=0", pass, err_cnt);
    end
  endtask

  task automatic test_cout_stuck;
    mode = 1;
    run_w1(1'b0);
    mode = 0;
    checks++;
    if (err_cnt !== 8'd4 || ffv !== 3'b011 || pass !== 1'b0) begin
      errors++; $display("FAIL cout_stuck got err=%0d ffv=%b pass=%b exp err=4 ffv=011 pass=0",
        err_cnt, ffv, pass);
    end
    checks++;
    if (done_cyc != 17) begin
      errors++; $display("FAIL cout_stuck_done got %0d exp 17", done_cyc);
    end
  endtask

  // Follows a failing run, so pass=1/err=0 also shows the results were cleared.
  task automatic test_restart;
    mode = 0;
    run_w1(1'b1);
    checks++;
    if (done_cyc != 17 || done_cnt != 1) begin
      errors++; $display("FAIL restart_ignored got cyc=%0d cnt=%0d exp cyc=17 cnt=1", done_cyc, done_cnt);
    end
    checks++;
    if (busy_tr[19] !== 1'b0 || busy_tr[18] !== 1'b0) begin
      errors++; $display("FAIL start_in_done_ignored got busy18=%b busy19=%b exp 0 0", busy_tr[18], busy_tr[19]);
    end
    checks++;
    if (pass !== 1'b1 || err_cnt !== 8'd0 || vec_tr[8] !== 3'd3) begin
      errors++; $display("FAIL rerun_cleared got pass=%b err=%0d vec8=%0d exp 1 0 3", pass, err_cnt, vec_tr[8]);
    end
  endtask

  task automatic test_reset_mid_run;
    int bad;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if ({bus1.a_o, bus1.b_o, bus1.cin_o} !== 3'd2 || busy !== 1'b1) begin
      errors++; $display("FAIL pre_abort got vec=%0d busy=%b exp 2 1", {bus1.a_o, bus1.b_o, bus1.cin_o}, busy);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus1.a_o, bus1.b_o, bus1.cin_o, busy, err_cnt, pass, done} !== '0) begin
      errors++; $display("FAIL async_abort got %b exp 0",
        {bus1.a_o, bus1.b_o, bus1.cin_o, busy, err_cnt, pass, done});
    end
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    bad = 0;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk); #1;
      if (done !== 1'b0 || busy !== 1'b0 || {bus1.a_o, bus1.b_o, bus1.cin_o} !== 3'd0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL idle_after_abort got %0d active cycles exp 0", bad);
    end
  endtask

  task automatic test_saturate_w2;
    int n;
    @(posedge clk); #1 start2 = 1'b1;
    @(posedge clk); #1 start2 = 1'b0;
    n = 1;
    while (done2 !== 1'b1 && n < 200) begin
      @(posedge clk); #1 n++;
    end
    checks++;
    if (n != 65) begin errors++; $display("FAIL w2_done_cycle got %0d exp 65", n); end
    checks++;
    if (err2 !== 4'd15 || ffv2 !== 5'd0 || pass2 !== 1'b0) begin
      errors++; $display("FAIL w2_saturate got err=%0d ffv=%0d pass=%b exp 15 0 0", err2, ffv2, pass2);
    end
  endtask

`ifdef ADDER_BIST_FAULT_INJ_EN
  task automatic test_fault_inj;
    mode = 0;
    fi = 1'b1;
    run_w1(1'b0);
    fi = 1'b0;
    checks++;
    if (err_cnt !== 8'd8 || ffv !== 3'd0 || pass !== 1'b0) begin
      errors++; $display("FAIL fault_inj got err=%0d ffv=%0d pass=%b exp 8 0 0", err_cnt, ffv, pass);
    end
    run_w1(1'b0);
    checks++;
    if (err_cnt !== 8'd0 || pass !== 1'b1) begin
      errors++; $display("FAIL fault_inj_off got err=%0d pass=%b exp 0 1", err_cnt, pass);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_golden();
    test_cout_stuck();
    test_restart();
    test_reset_mid_run();
    test_saturate_w2();
`ifdef ADDER_BIST_FAULT_INJ_EN
    test_fault_inj();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
